// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transceiver: FSM state encodings,
// parity modes, the parity function and the bit-timer width.
package uart_pkg;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_CLEANUP
   } rx_state_t;

   localparam int PARITY_NONE   = 0;
   localparam int PARITY_EVEN   = 1;
   localparam int PARITY_ODD    = 2;
   localparam int MAX_DATA_BITS = 9;

   // Callers zero-extend the payload, so unused upper bits never change the result.
   function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data, input int mode);
      case (mode)
         PARITY_EVEN: return ^data;
         PARITY_ODD:  return ~^data;
         default:     return 1'b0;
      endcase
   endfunction

   function automatic int timer_width(input int clks);
      return $clog2(clks);
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter; tc is high for the single cycle in which a loaded
// count has reached zero, so a load of N-1 gives a period of N cycles.
module uart_bit_timer #(
   parameter int W = 4
) (
   input  logic         clk_sys,
   input  logic         rst_b,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tc
);

   logic [W-1:0] cnt_q;
   logic         run_q;

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (load) begin
         cnt_q <= load_val;
         run_q <= 1'b1;
      end else if (run_q) begin
         if (cnt_q == '0) run_q <= 1'b0;
         else             cnt_q <= cnt_q - 1'b1;
      end
   end

   assign tc = run_q && (cnt_q == '0);

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex UART: independent TX and RX engines, each paced by its own bit timer.
//
// state      | meaning
// TX_IDLE    | line high, waiting for i_Tx_DV
// TX_START   | driving start bit
// TX_DATA    | shifting payload out LSB first
// TX_PARITY  | driving parity bit
// TX_STOP    | driving STOP_BITS stop bits
// RX_IDLE    | waiting for synchronised low
// RX_START   | half-bit wait, then confirm start bit
// RX_DATA    | sampling payload mid-bit
// RX_PARITY  | sampling parity bit
// RX_STOP    | sampling first stop bit, then report frame
// RX_CLEANUP | waiting for line high before re-arming
module uart_transceiver
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 i_Clock,
   input  logic                 KEY_rst,
   input  logic                 i_Tx_DV,
   input  logic [DATA_BITS-1:0] i_Tx_Byte,
   output logic                 o_Tx_Active,
   output logic                 o_Tx_Serial,
   output logic                 o_Tx_Done,
   input  logic                 i_Rx_Serial,
   output logic                 o_Rx_DV,
   output logic [DATA_BITS-1:0] o_Rx_Byte,
   output logic                 o_Rx_Parity_Err,
   output logic                 o_Rx_Frame_Err
);

   localparam int             TW         = timer_width(CLKS_PER_BIT);
   localparam logic [TW-1:0]  BIT_LOAD   = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0]  HALF_LOAD  = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [3:0]     LAST_BIT   = 4'(DATA_BITS - 1);
   localparam logic           LAST_STOP  = 1'(STOP_BITS - 1);
   localparam bit             HAS_PARITY = (PARITY_MODE != PARITY_NONE);

   tx_state_t            tx_state_q, tx_state_d;
   logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
   logic [3:0]           tx_bit_q, tx_bit_d;
   logic                 tx_stop_q, tx_stop_d;
   logic                 tx_par_q, tx_par_d;
   logic                 tx_serial_q, tx_serial_d;
   logic                 tx_load, tx_tc;

   uart_bit_timer #(.W(TW)) u_tx_timer (
      .clk_sys  (i_Clock),
      .rst_b    (KEY_rst),
      .load     (tx_load),
      .load_val (BIT_LOAD),
      .tc       (tx_tc)
   );

   always_ff @(posedge i_Clock or negedge KEY_rst) begin
      if (!KEY_rst) begin
         tx_state_q  <= TX_IDLE;
         tx_data_q   <= '0;
         tx_bit_q    <= '0;
         tx_stop_q   <= 1'b0;
         tx_par_q    <= 1'b0;
         tx_serial_q <= 1'b1;
      end else begin
         tx_state_q  <= tx_state_d;
         tx_data_q   <= tx_data_d;
         tx_bit_q    <= tx_bit_d;
         tx_stop_q   <= tx_stop_d;
         tx_par_q    <= tx_par_d;
         tx_serial_q <= tx_serial_d;
      end
   end

   always_comb begin
      tx_state_d  = tx_state_q;
      tx_data_d   = tx_data_q;
      tx_bit_d    = tx_bit_q;
      tx_stop_d   = tx_stop_q;
      tx_par_d    = tx_par_q;
      tx_serial_d = tx_serial_q;
      tx_load     = 1'b0;
      case (tx_state_q)
         TX_IDLE: begin
            tx_serial_d = 1'b1;
            if (i_Tx_DV) begin
               tx_data_d   = i_Tx_Byte;
               tx_par_d    = calc_parity(MAX_DATA_BITS'(i_Tx_Byte), PARITY_MODE);
               tx_bit_d    = '0;
               tx_stop_d   = 1'b0;
               tx_serial_d = 1'b0;
               tx_load     = 1'b1;
               tx_state_d  = TX_START;
            end
         end
         TX_START: if (tx_tc) begin
            tx_serial_d = tx_data_q[0];
            tx_load     = 1'b1;
            tx_state_d  = TX_DATA;
         end
         TX_DATA: if (tx_tc) begin
            tx_load = 1'b1;
            if (tx_bit_q == LAST_BIT) begin
               if (HAS_PARITY) begin
                  tx_serial_d = tx_par_q;
                  tx_state_d  = TX_PARITY;
               end else begin
                  tx_serial_d = 1'b1;
                  tx_state_d  = TX_STOP;
               end
            end else begin
               tx_data_d   = tx_data_q >> 1;
               tx_serial_d = tx_data_q[1];
               tx_bit_d    = tx_bit_q + 4'd1;
            end
         end
         TX_PARITY: if (tx_tc) begin
            tx_serial_d = 1'b1;
            tx_load     = 1'b1;
            tx_state_d  = TX_STOP;
         end
         TX_STOP: if (tx_tc) begin
            if (tx_stop_q == LAST_STOP) begin
               tx_state_d = TX_IDLE;
            end else begin
               tx_stop_d = tx_stop_q + 1'b1;
               tx_load   = 1'b1;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   assign o_Tx_Serial = tx_serial_q;
   assign o_Tx_Active = (tx_state_q != TX_IDLE);
   assign o_Tx_Done   = (tx_state_q == TX_STOP) && tx_tc && (tx_stop_q == LAST_STOP);

   rx_state_t            rx_state_q, rx_state_d;
   logic                 rx_meta_q, rx_sync_q;
   logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
   logic [3:0]           rx_bit_q, rx_bit_d;
   logic                 rx_par_q, rx_par_d;
   logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
   logic                 rx_perr_q, rx_perr_d;
   logic                 rx_ferr_q, rx_ferr_d;
   logic                 rx_dv_q, rx_dv_d;
   logic                 rx_load, rx_tc;
   logic [TW-1:0]        rx_load_val;

   uart_bit_timer #(.W(TW)) u_rx_timer (
      .clk_sys  (i_Clock),
      .rst_b    (KEY_rst),
      .load     (rx_load),
      .load_val (rx_load_val),
      .tc       (rx_tc)
   );

   always_ff @(posedge i_Clock or negedge KEY_rst) begin
      if (!KEY_rst) begin
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_shift_q <= '0;
         rx_bit_q   <= '0;
         rx_par_q   <= 1'b0;
         rx_byte_q  <= '0;
         rx_perr_q  <= 1'b0;
         rx_ferr_q  <= 1'b0;
         rx_dv_q    <= 1'b0;
      end else begin
         rx_meta_q  <= i_Rx_Serial;
         rx_sync_q  <= rx_meta_q;
         rx_state_q <= rx_state_d;
         rx_shift_q <= rx_shift_d;
         rx_bit_q   <= rx_bit_d;
         rx_par_q   <= rx_par_d;
         rx_byte_q  <= rx_byte_d;
         rx_perr_q  <= rx_perr_d;
         rx_ferr_q  <= rx_ferr_d;
         rx_dv_q    <= rx_dv_d;
      end
   end

   always_comb begin
      rx_state_d  = rx_state_q;
      rx_shift_d  = rx_shift_q;
      rx_bit_d    = rx_bit_q;
      rx_par_d    = rx_par_q;
      rx_byte_d   = rx_byte_q;
      rx_perr_d   = rx_perr_q;
      rx_ferr_d   = rx_ferr_q;
      rx_dv_d     = 1'b0;
      rx_load     = 1'b0;
      rx_load_val = BIT_LOAD;
      case (rx_state_q)
         RX_IDLE: if (!rx_sync_q) begin
            rx_load_val = HALF_LOAD;
            rx_load     = 1'b1;
            rx_state_d  = RX_START;
         end
         RX_START: if (rx_tc) begin
            if (rx_sync_q) begin
               rx_state_d = RX_IDLE;
            end else begin
               rx_bit_d   = '0;
               rx_load    = 1'b1;
               rx_state_d = RX_DATA;
            end
         end
         RX_DATA: if (rx_tc) begin
            rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
            rx_bit_d   = rx_bit_q + 4'd1;
            rx_load    = 1'b1;
            if (rx_bit_q == LAST_BIT) rx_state_d = HAS_PARITY ? RX_PARITY : RX_STOP;
         end
         RX_PARITY: if (rx_tc) begin
            rx_par_d   = rx_sync_q;
            rx_load    = 1'b1;
            rx_state_d = RX_STOP;
         end
         RX_STOP: if (rx_tc) begin
            rx_byte_d  = rx_shift_q;
            rx_perr_d  = HAS_PARITY &&
                         (calc_parity(MAX_DATA_BITS'(rx_shift_q), PARITY_MODE) != rx_par_q);
            rx_ferr_d  = !rx_sync_q;
            rx_dv_d    = 1'b1;
            rx_state_d = RX_CLEANUP;
         end
         RX_CLEANUP: if (rx_sync_q) rx_state_d = RX_IDLE;
         default: rx_state_d = RX_IDLE;
      endcase
   end

   assign o_Rx_DV         = rx_dv_q;
   assign o_Rx_Byte       = rx_byte_q;
   assign o_Rx_Parity_Err = rx_perr_q;
   assign o_Rx_Frame_Err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver: a loopback instance (8 clk/bit, even parity),
// an RX-injection instance (7-bit odd parity) and a 16 clk/bit, no-parity, 2-stop instance.
module tb_uart_transceiver;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   logic       tx_dv_a, tx_act_a, tx_ser_a, tx_done_a, rx_dv_a, rx_pe_a, rx_fe_a;
   logic [7:0] tx_byte_a, rx_byte_a;
   logic       tx_dv_b, tx_act_b, tx_ser_b, tx_done_b, rx_b, rx_dv_b, rx_pe_b, rx_fe_b;
   logic [6:0] tx_byte_b, rx_byte_b;
   logic       tx_dv_c, tx_act_c, tx_ser_c, tx_done_c, rx_c, rx_dv_c, rx_pe_c, rx_fe_c;
   logic [7:0] tx_byte_c, rx_byte_c;

   uart_transceiver #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) dut_a (
      .i_Clock(clk), .KEY_rst(rst_n), .i_Tx_DV(tx_dv_a), .i_Tx_Byte(tx_byte_a),
      .o_Tx_Active(tx_act_a), .o_Tx_Serial(tx_ser_a), .o_Tx_Done(tx_done_a),
      .i_Rx_Serial(tx_ser_a), .o_Rx_DV(rx_dv_a), .o_Rx_Byte(rx_byte_a),
      .o_Rx_Parity_Err(rx_pe_a), .o_Rx_Frame_Err(rx_fe_a));

   uart_transceiver #(.CLKS_PER_BIT(8), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1)) dut_b (
      .i_Clock(clk), .KEY_rst(rst_n), .i_Tx_DV(tx_dv_b), .i_Tx_Byte(tx_byte_b),
      .o_Tx_Active(tx_act_b), .o_Tx_Serial(tx_ser_b), .o_Tx_Done(tx_done_b),
      .i_Rx_Serial(rx_b), .o_Rx_DV(rx_dv_b), .o_Rx_Byte(rx_byte_b),
      .o_Rx_Parity_Err(rx_pe_b), .o_Rx_Frame_Err(rx_fe_b));

   uart_transceiver #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) dut_c (
      .i_Clock(clk), .KEY_rst(rst_n), .i_Tx_DV(tx_dv_c), .i_Tx_Byte(tx_byte_c),
      .o_Tx_Active(tx_act_c), .o_Tx_Serial(tx_ser_c), .o_Tx_Done(tx_done_c),
      .i_Rx_Serial(rx_c), .o_Rx_DV(rx_dv_c), .o_Rx_Byte(rx_byte_c),
      .o_Rx_Parity_Err(rx_pe_c), .o_Rx_Frame_Err(rx_fe_c));

   int   sel = 0;
   logic m_ser, m_act, m_done;
   always_comb begin
      m_ser  = (sel == 0) ? tx_ser_a  : tx_ser_c;
      m_act  = (sel == 0) ? tx_act_a  : tx_act_c;
      m_done = (sel == 0) ? tx_done_a : tx_done_c;
   end

   int dv_cnt_b = 0;
   int dv_cnt_c = 0;
   always @(negedge clk) begin
      if (rx_dv_b) dv_cnt_b++;
      if (rx_dv_c) dv_cnt_c++;
   end

   typedef struct {
      logic [7:0]  data;
      logic [10:0] frame;
   } tx_vec_t;

   typedef struct {
      logic [10:0] bits;
      logic [6:0]  data;
      logic        perr;
   } rx_vec_t;

   tx_vec_t tx_vecs[6];
   rx_vec_t rx_vecs[6];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Sends one byte on the selected TX, samples every bit mid-way and tracks done/active;
   // on the loopback instance it also collects the received frame.
   task automatic tx_frame(input int s, input logic [7:0] data, input logic [10:0] frame,
                           input int clks, input string name);
      logic [10:0] got;
      logic [7:0]  rxb;
      logic        pe, fe;
      int          done_n, done_at, inact, dv_n, dv_at;
      got = '0; rxb = '0; pe = 1'b0; fe = 1'b0;
      done_n = 0; done_at = -1; inact = 0; dv_n = 0; dv_at = -1;
      sel = s;
      if (s == 0) begin tx_dv_a = 1'b1; tx_byte_a = data; end
      else        begin tx_dv_c = 1'b1; tx_byte_c = data; end
      @(posedge clk); #1;
      chk({name, " accept_active"}, 32'(m_act), 1);
      chk({name, " accept_start"}, 32'(m_ser), 0);
      tx_byte_a = ~data;
      tx_byte_c = ~data;
      for (int c = 0; c < 11 * clks; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         if (c == 10) begin tx_dv_a = 1'b0; tx_dv_c = 1'b0; end
         if (c % clks == clks / 2) got = {m_ser, got[10:1]};
         if (m_done) begin done_n++; done_at = c; end
         if (!m_act) inact++;
         if (rx_dv_a) begin dv_n++; dv_at = c; rxb = rx_byte_a; pe = rx_pe_a; fe = rx_fe_a; end
      end
      @(posedge clk); #1;
      chk({name, " frame_bits"}, 32'(got), 32'(frame));
      chk({name, " done_count"}, 32'(done_n), 1);
      chk({name, " done_cycle"}, 32'(done_at), 32'(11 * clks - 1));
      chk({name, " active_gaps"}, 32'(inact), 0);
      chk({name, " active_fall"}, 32'(m_act), 0);
      chk({name, " line_idle"}, 32'(m_ser), 1);
      if (s == 0) begin
         chk({name, " rx_dv_count"}, 32'(dv_n), 1);
         chk({name, " rx_latency"}, 32'(dv_at >= 85 && dv_at <= 87), 1);
         chk({name, " rx_dv_width"}, 32'(rx_dv_a), 0);
         chk({name, " rx_byte"}, 32'(rxb), 32'(data));
         chk({name, " rx_perr"}, 32'(pe), 0);
         chk({name, " rx_ferr"}, 32'(fe), 0);
      end
   endtask

   // Drives n bits, bit 0 first, onto rx_b (s=1) or rx_c (s=2); the line keeps the last bit.
   task automatic drive_rx(input int s, input logic [10:0] bits, input int n, input int clks);
      logic [10:0] b;
      b = bits;
      for (int i = 0; i < n; i++) begin
         if (s == 1) rx_b = b[0];
         else        rx_c = b[0];
         b = b >> 1;
         repeat (clks) @(negedge clk);
      end
   endtask

   int d0;

   initial begin
      tx_vecs[0] = '{8'hA5, 11'b1_0_10100101_0};
      tx_vecs[1] = '{8'h00, 11'b1_0_00000000_0};
      tx_vecs[2] = '{8'hFF, 11'b1_0_11111111_0};
      tx_vecs[3] = '{8'h01, 11'b1_1_00000001_0};
      tx_vecs[4] = '{8'h37, 11'b1_1_00110111_0};
      tx_vecs[5] = '{8'h80, 11'b1_1_10000000_0};

      rx_vecs[0] = '{11'b11_0_0110101_0, 7'h35, 1'b1};
      rx_vecs[1] = '{11'b11_1_0110101_0, 7'h35, 1'b0};
      rx_vecs[2] = '{11'b11_1_0000000_0, 7'h00, 1'b0};
      rx_vecs[3] = '{11'b11_0_1111111_0, 7'h7F, 1'b0};
      rx_vecs[4] = '{11'b11_1_1111111_0, 7'h7F, 1'b1};
      rx_vecs[5] = '{11'b11_0_0101010_0, 7'h2A, 1'b0};

      tx_dv_a = 1'b0; tx_byte_a = '0;
      tx_dv_b = 1'b0; tx_byte_b = '0; rx_b = 1'b1;
      tx_dv_c = 1'b0; tx_byte_c = '0; rx_c = 1'b1;

      repeat (2) @(negedge clk);
      chk("rst tx_serial", 32'(tx_ser_a), 1);
      chk("rst tx_active", 32'(tx_act_a), 0);
      chk("rst tx_done", 32'(tx_done_a), 0);
      chk("rst rx_dv", 32'(rx_dv_a), 0);
      chk("rst rx_byte", 32'(rx_byte_a), 0);
      chk("rst rx_perr", 32'(rx_pe_a), 0);
      chk("rst rx_ferr", 32'(rx_fe_a), 0);
      chk("rst c tx_serial", 32'(tx_ser_c), 1);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      for (int i = 0; i < 6; i++)
         tx_frame(0, tx_vecs[i].data, tx_vecs[i].frame, 8, $sformatf("lb%0d", i));

      repeat (5) @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         d0 = dv_cnt_b;
         drive_rx(1, rx_vecs[i].bits, 11, 8);
         rx_b = 1'b1;
         repeat (16) @(negedge clk);
         chk($sformatf("rxb%0d dv_count", i), 32'(dv_cnt_b - d0), 1);
         chk($sformatf("rxb%0d byte", i), 32'(rx_byte_b), 32'(rx_vecs[i].data));
         chk($sformatf("rxb%0d perr", i), 32'(rx_pe_b), 32'(rx_vecs[i].perr));
         chk($sformatf("rxb%0d ferr", i), 32'(rx_fe_b), 0);
      end

      // stop bit low, then a 5 bit-time break
      d0 = dv_cnt_b;
      drive_rx(1, 11'b0_0_1_0110101_0, 10, 8);
      repeat (40) @(negedge clk);
      chk("break dv_count", 32'(dv_cnt_b - d0), 1);
      chk("break ferr", 32'(rx_fe_b), 1);
      chk("break byte", 32'(rx_byte_b), 32'h35);
      rx_b = 1'b1;
      repeat (40) @(negedge clk);
      chk("break release no_dv", 32'(dv_cnt_b - d0), 1);
      drive_rx(1, 11'b11_1_0110101_0, 11, 8);
      rx_b = 1'b1;
      repeat (16) @(negedge clk);
      chk("after_break dv_count", 32'(dv_cnt_b - d0), 2);
      chk("after_break ferr", 32'(rx_fe_b), 0);

      d0 = dv_cnt_c;
      rx_c = 1'b0;
      repeat (3) @(negedge clk);
      rx_c = 1'b1;
      repeat (60) @(negedge clk);
      chk("glitch no_dv", 32'(dv_cnt_c - d0), 0);
      drive_rx(2, 11'b11_11000011_0, 11, 16);
      rx_c = 1'b1;
      repeat (20) @(negedge clk);
      chk("glitch recover dv_count", 32'(dv_cnt_c - d0), 1);
      chk("glitch recover byte", 32'(rx_byte_c), 32'hC3);
      chk("glitch recover perr", 32'(rx_pe_c), 0);
      chk("glitch recover ferr", 32'(rx_fe_c), 0);

      tx_frame(1, 8'hC3, 11'b1_1_11000011_0, 16, "c_2stop");

      // reset in the middle of data bit 3 while the loopback RX is mid-frame
      repeat (3) @(negedge clk);
      sel = 0;
      tx_dv_a = 1'b1; tx_byte_a = 8'hA5;
      @(posedge clk); #1;
      tx_dv_a = 1'b0;
      repeat (35) @(posedge clk);
      #1;
      chk("pre_rst bit3", 32'(tx_ser_a), 0);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst tx_serial", 32'(tx_ser_a), 1);
      chk("mid_rst tx_active", 32'(tx_act_a), 0);
      chk("mid_rst tx_done", 32'(tx_done_a), 0);
      chk("mid_rst rx_dv", 32'(rx_dv_a), 0);
      chk("mid_rst rx_byte", 32'(rx_byte_a), 0);
      chk("mid_rst rx_perr", 32'(rx_pe_a), 0);
      chk("mid_rst rx_ferr", 32'(rx_fe_a), 0);
      chk("mid_rst b rx_byte", 32'(rx_byte_b), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      tx_frame(0, 8'h5A, 11'b1_0_01011010_0, 8, "post_rst");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
